// File: rtl/pipe_pkg.sv
// Shared types and helpers for the forwarding/hazard unit: the per-stage shadow
// record, the select-width calculation and the forward-select encoding.
package pipe_pkg;

   localparam int MAX_AW = 8;
   localparam int FWD_RF = 0;

   typedef struct packed {
      logic              vld;
      logic              regwr;
      logic              load;
      logic              store;
      logic [MAX_AW-1:0] rd;
      logic [MAX_AW-1:0] rt;
   } shadow_t;

   function automatic int sel_w(input int nstg);
      return $clog2(nstg);
   endfunction

   // Stage k's result is selected with code k-1 so that 0 can mean register file.
   function automatic int fwd_code(input int stg);
      return stg - 1;
   endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-side request and forwarding/stall response bundle of the hazard unit.
interface fwd_hazard_unit_if #(
   parameter int REG_AW = 5,
   parameter int NSTG   = 3,
   parameter int CNT_W  = 16
);
   import pipe_pkg::*;

   localparam int SELW = sel_w(NSTG);

   logic              id_valid;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic [REG_AW-1:0] id_rd;
   logic              id_regwr;
   logic              id_memread;
   logic              id_memwrite;
   logic              flush;
   logic              hold;

   logic              stall;
   logic [SELW-1:0]   fwd_a;
   logic [SELW-1:0]   fwd_b;
   logic              fwd_mem;
   logic [CNT_W-1:0]  stall_cnt;

   modport master (
      output id_valid, id_rs, id_rt, id_rd, id_regwr, id_memread, id_memwrite,
             flush, hold,
      input  stall, fwd_a, fwd_b, fwd_mem, stall_cnt
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_rd, id_regwr, id_memread, id_memwrite,
             flush, hold,
      output stall, fwd_a, fwd_b, fwd_mem, stall_cnt
   );

endinterface

// File: rtl/fwd_select.sv
// Priority match of one EX operand against the forwardable producers in stages 2..NSTG.
module fwd_select
   import pipe_pkg::*;
#(
   parameter int NSTG = 3,
   parameter int SELW = sel_w(NSTG)
) (
   input  logic [NSTG:2]             cand,
   input  logic [NSTG:2][MAX_AW-1:0] cand_rd,
   input  logic [MAX_AW-1:0]         src,
   output logic [SELW-1:0]           sel
);

   // Walk from the oldest stage down so the youngest matching producer wins.
   always_comb begin
      sel = SELW'(FWD_RF);
      for (int s = NSTG; s >= 2; s--) begin
         if (cand[s] && cand_rd[s] == src)
            sel = SELW'(fwd_code(s));
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Pipeline shadow of EX..stage NSTG producing operand forward selects, store-data
// forwarding and the load-use stall, with a saturating stall counter.
module fwd_hazard_unit
   import pipe_pkg::*;
#(
   parameter int REG_AW   = 5,
   parameter int NSTG     = 3,
   parameter int LOAD_STG = 3,
   parameter int CNT_W    = 16
) (
   input logic              clk,
   input logic              rst_n,
   fwd_hazard_unit_if.slave bus
);

   localparam int SELW = sel_w(NSTG);

   shadow_t [NSTG:1]           stg_q;
   logic [MAX_AW-1:0]          ex_rs_q;
   logic [CNT_W-1:0]           cnt_q;

   logic [MAX_AW-1:0]          id_rs_x;
   logic [MAX_AW-1:0]          id_rt_x;
   logic                       load_use;
   logic                       stall;
   logic                       issue;
   shadow_t                    id_entry;
   logic [NSTG:2]              cand;
   logic [NSTG:2][MAX_AW-1:0]  cand_rd;
   logic [SELW-1:0]            sel_a;
   logic [SELW-1:0]            sel_b;
   logic                       fwd_mem;
   logic                       unused_stg;

   assign id_rs_x = MAX_AW'(bus.id_rs);
   assign id_rt_x = MAX_AW'(bus.id_rt);

   // A store only needs rt in MEM, where fwd_mem supplies it, so rt never stalls a store.
   always_comb begin
      load_use = 1'b0;
      for (int s = 1; s <= NSTG; s++) begin
         if ((s + 1 < LOAD_STG) && stg_q[s].vld && stg_q[s].load && (stg_q[s].rd != '0) &&
             ((stg_q[s].rd == id_rs_x) || ((stg_q[s].rd == id_rt_x) && !bus.id_memwrite)))
            load_use = 1'b1;
      end
   end

   assign stall = bus.id_valid && !bus.flush && load_use;
   assign issue = bus.id_valid && !bus.flush && !stall;

   always_comb begin
      id_entry = '0;
      if (issue) begin
         id_entry.vld   = 1'b1;
         id_entry.regwr = bus.id_regwr;
         id_entry.load  = bus.id_memread;
         id_entry.store = bus.id_memwrite;
         id_entry.rd    = MAX_AW'(bus.id_rd);
         id_entry.rt    = id_rt_x;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stg_q   <= '0;
         ex_rs_q <= '0;
         cnt_q   <= '0;
      end else if (!bus.hold) begin
         for (int s = NSTG; s >= 2; s--)
            stg_q[s] <= stg_q[s-1];
         stg_q[1] <= id_entry;
         ex_rs_q  <= issue ? id_rs_x : '0;
         if (stall && (cnt_q != '1))
            cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // Loads younger than LOAD_STG have no data yet; they neither match nor hide older producers.
   always_comb begin
      cand    = '0;
      cand_rd = '0;
      for (int s = 2; s <= NSTG; s++) begin
         cand[s]    = stg_q[s].vld && stg_q[s].regwr && (stg_q[s].rd != '0) &&
                      (!stg_q[s].load || (s >= LOAD_STG));
         cand_rd[s] = stg_q[s].rd;
      end
   end

   fwd_select #(.NSTG(NSTG), .SELW(SELW)) u_sel_a (
      .cand    (cand),
      .cand_rd (cand_rd),
      .src     (ex_rs_q),
      .sel     (sel_a)
   );

   fwd_select #(.NSTG(NSTG), .SELW(SELW)) u_sel_b (
      .cand    (cand),
      .cand_rd (cand_rd),
      .src     (stg_q[1].rt),
      .sel     (sel_b)
   );

   assign fwd_mem = stg_q[2].vld && stg_q[2].store && stg_q[3].vld && stg_q[3].load &&
                    (stg_q[3].rd != '0) && (stg_q[3].rd == stg_q[2].rt);

   assign unused_stg = ^stg_q;

   assign bus.stall     = stall;
   assign bus.fwd_a     = sel_a;
   assign bus.fwd_b     = sel_b;
   assign bus.fwd_mem   = fwd_mem;
   assign bus.stall_cnt = cnt_q;

endmodule
